// File: rtl/uart_alu_ctrl_if.sv
// Bus between the UART-to-ALU frame controller and its environment.
// The slave side is the controller. The master side is the UART, ALU and TX logic.
interface uart_alu_ctrl_if #(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic               o_tx_start;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_busy;
    logic               o_error;
    logic               o_drop;

    modport slave (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
               o_busy, o_error, o_drop
    );

    modport master (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_start, o_tx_data,
               o_busy, o_error, o_drop
    );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Collects an A/B/OP byte frame from the UART receiver and drives the ALU operands.
// It then hands the ALU result to the transmitter and waits for the transmitter to finish.
// Errors are raised for an inter-byte timeout and for an unknown opcode.
module uart_alu_ctrl #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int NB_TIMEOUT     = 20
) (
    input  logic           i_clock,
    input  logic           i_reset,
    uart_alu_ctrl_if.slave bus
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_GET_B   = 3'd1;
    localparam logic [2:0] ST_GET_OP  = 3'd2;
    localparam logic [2:0] ST_SEND    = 3'd3;
    localparam logic [2:0] ST_WAIT_TX = 3'd4;

    localparam logic [NB_TIMEOUT-1:0] CNT_LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [2:0]            r_state;
    logic [NB_TIMEOUT-1:0] r_cnt;
    logic [NB_DATA-1:0]    r_alu_a;
    logic [NB_DATA-1:0]    r_alu_b;
    logic [NB_OP-1:0]      r_alu_op;
    logic [NB_DATA-1:0]    r_tx_data;
    logic                  r_error;
    logic                  r_drop;

    logic [NB_OP-1:0]      w_op;
    logic                  w_op_valid;
    logic                  w_timeout;
    logic                  w_cnt_sat;

    assign w_op      = bus.i_rx_data[NB_OP-1:0];
    assign w_timeout = (r_cnt == CNT_LAST);
    assign w_cnt_sat = &r_cnt;

    // Accept only the eight opcodes the ALU implements. Bits above NB_OP are don't-care.
    always_comb begin
        w_op_valid = 1'b0;
        case (w_op)
            NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
            NB_OP'(6'b100110), NB_OP'(6'b100111), NB_OP'(6'b000011), NB_OP'(6'b000010):
                w_op_valid = 1'b1;
            default: w_op_valid = 1'b0;
        endcase
    end

    // Frame FSM. The rx strobe is tested before the timeout so that a byte arriving on the last cycle is kept.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_tx_data <= '0;
            r_error   <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_error <= 1'b0;
            r_drop  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (bus.i_rx_done) begin
                        r_alu_a <= bus.i_rx_data;
                        r_state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (bus.i_rx_done) begin
                        r_alu_b <= bus.i_rx_data;
                        r_cnt   <= '0;
                        r_state <= ST_GET_OP;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_GET_OP: begin
                    if (bus.i_rx_done) begin
                        r_cnt <= '0;
                        if (w_op_valid) begin
                            r_alu_op <= w_op;
                            r_state  <= ST_SEND;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    r_cnt     <= '0;
                    r_tx_data <= bus.i_alu_result;
                    r_drop    <= bus.i_rx_done;
                    r_state   <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    r_cnt  <= '0;
                    r_drop <= bus.i_rx_done;
                    if (bus.i_tx_done) r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // In SEND the operands were latched on the previous edge, so the ALU output is already valid.
    // Passing it through lets o_tx_start and o_tx_data appear in the same cycle, one cycle after the OP byte.
    // The registered copy holds the value after that cycle.
    assign bus.o_tx_start = (r_state == ST_SEND);
    assign bus.o_tx_data  = (r_state == ST_SEND) ? bus.i_alu_result : r_tx_data;
    assign bus.o_busy     = (r_state == ST_SEND) || (r_state == ST_WAIT_TX);
    assign bus.o_alu_a    = r_alu_a;
    assign bus.o_alu_b    = r_alu_b;
    assign bus.o_alu_op   = r_alu_op;
    assign bus.o_error    = r_error;
    assign bus.o_drop     = r_drop;
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl. A behavioural ALU drives i_alu_result.
// A frame-level model predicts every output on every cycle.
module tb_uart_alu_ctrl;
    localparam int NBD = 8;
    localparam int NBO = 6;
    localparam int TO  = 16;
    localparam int NBT = 5;

    logic i_clock = 1'b0;
    logic i_reset;
    always #5 i_clock = ~i_clock;

    uart_alu_ctrl_if #(.NB_DATA(NBD), .NB_OP(NBO)) bus();

    uart_alu_ctrl #(.NB_DATA(NBD), .NB_OP(NBO), .TIMEOUT_CYCLES(TO), .NB_TIMEOUT(NBT)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [5:0] valid_ops [8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                  6'b100110, 6'b100111, 6'b000011, 6'b000010};

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'b100000: alu = a + b;
            6'b100010: alu = a - b;
            6'b100100: alu = a & b;
            6'b100101: alu = a | b;
            6'b100110: alu = a ^ b;
            6'b100111: alu = ~(a | b);
            6'b000011: alu = 8'($signed(a) >>> b[2:0]);
            6'b000010: alu = a >> b[2:0];
            default:   alu = 8'hEE;
        endcase
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        op_ok = 1'b0;
        foreach (valid_ops[k]) if (valid_ops[k] == op) op_ok = 1'b1;
    endfunction

    assign bus.i_alu_result = alu(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    // Frame-level reference. The model tracks how many frame bytes are held and how long the line has been quiet.
    // It also tracks whether a result is being announced or is in transmission.
    int         m_nbytes, m_silence;
    bit         m_announce, m_in_tx, m_err, m_drop;
    logic [7:0] m_a, m_b, m_txd;
    logic [5:0] m_op;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit rst, input bit rxd, input logic [7:0] d, input bit txd);
        m_err  = 1'b0;
        m_drop = 1'b0;
        if (rst) begin
            m_nbytes = 0; m_silence = 0; m_announce = 1'b0; m_in_tx = 1'b0;
            m_a = '0; m_b = '0; m_op = '0; m_txd = '0;
        end else if (m_announce) begin
            m_drop     = rxd;
            m_txd      = alu(m_a, m_b, m_op);
            m_announce = 1'b0;
            m_in_tx    = 1'b1;
        end else if (m_in_tx) begin
            m_drop = rxd;
            if (txd) m_in_tx = 1'b0;
        end else if (rxd) begin
            m_silence = 0;
            if (m_nbytes == 0) begin
                m_a = d; m_nbytes = 1;
            end else if (m_nbytes == 1) begin
                m_b = d; m_nbytes = 2;
            end else begin
                m_nbytes = 0;
                if (op_ok(d[5:0])) begin m_op = d[5:0]; m_announce = 1'b1; end
                else m_err = 1'b1;
            end
        end else if (m_nbytes > 0) begin
            m_silence++;
            if (m_silence == TO) begin
                m_err = 1'b1; m_nbytes = 0; m_silence = 0;
            end
        end
    endtask

    // One clock with the given inputs. Outputs are compared 1 time unit after the edge.
    task automatic cyc(input bit rst, input bit rxd, input logic [7:0] d, input bit txd);
        i_reset       = rst;
        bus.i_rx_done = rxd;
        bus.i_rx_data = d;
        bus.i_tx_done = txd;
        @(posedge i_clock);
        #1;
        model(rst, rxd, d, txd);
        i_reset       = 1'b0;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        chk("alu_a",    32'(bus.o_alu_a),    32'(m_a));
        chk("alu_b",    32'(bus.o_alu_b),    32'(m_b));
        chk("alu_op",   32'(bus.o_alu_op),   32'(m_op));
        chk("tx_start", 32'(bus.o_tx_start), 32'(m_announce));
        chk("tx_data",  32'(bus.o_tx_data),  32'(m_announce ? alu(m_a, m_b, m_op) : m_txd));
        chk("busy",     32'(bus.o_busy),     32'(m_announce | m_in_tx));
        chk("error",    32'(bus.o_error),    32'(m_err));
        chk("drop",     32'(bus.o_drop),     32'(m_drop));
        if (bus.o_tx_start === 1'b1) chk("start_vs_error", 32'(bus.o_error), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic rx(input logic [7:0] d);
        cyc(1'b0, 1'b1, d, 1'b0);
    endtask

    initial begin
        i_reset = 1'b1; bus.i_rx_done = 1'b0; bus.i_rx_data = '0; bus.i_tx_done = 1'b0;
        model(1'b1, 1'b0, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 8'h00, 1'b0);
        chk("reset_alu_a", 32'(bus.o_alu_a), 32'd0);

        // ADD frame. The result is announced one cycle after the OP byte.
        rx(8'h05); idle(2); rx(8'h03); idle(1); rx(8'h20);
        chk("add_start", 32'(bus.o_tx_start), 32'd1);
        chk("add_data",  32'(bus.o_tx_data),  32'h08);
        idle(4);
        chk("add_busy",  32'(bus.o_busy),     32'd1);
        cyc(1'b0, 1'b0, 8'h00, 1'b1);
        chk("add_done",  32'(bus.o_busy),     32'd0);

        // Invalid opcode 111111. The frame gives one error pulse and the opcode register keeps 0x20.
        rx(8'h0F); rx(8'h01); rx(8'h3F);
        chk("badop_err", 32'(bus.o_error),  32'd1);
        chk("badop_op",  32'(bus.o_alu_op), 32'h20);
        idle(2);

        // Timeout after byte A. A fresh byte then starts a new frame.
        rx(8'hAA); idle(TO - 1);
        chk("to_quiet", 32'(bus.o_error), 32'd0);
        idle(1);
        chk("to_err",   32'(bus.o_error), 32'd1);
        idle(2); rx(8'h11);
        chk("to_new_a", 32'(bus.o_alu_a), 32'h11);
        idle(1);
        rx(8'h22); rx(8'h24); idle(2); cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // A byte that arrives during transmission is dropped.
        rx(8'h33); rx(8'h44); rx(8'hE6); idle(2);
        rx(8'h99);
        chk("drop_pulse", 32'(bus.o_drop),    32'd1);
        chk("drop_keep",  32'(bus.o_tx_data), 32'h77);
        idle(1); cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Reset after byte B abandons the frame. A complete frame is then processed normally.
        rx(8'h12); rx(8'h34); cyc(1'b1, 1'b1, 8'h56, 1'b0);
        chk("rst_alu_b", 32'(bus.o_alu_b), 32'd0);
        rx(8'h40); rx(8'h02); rx(8'h02);
        chk("rst_frame", 32'(bus.o_tx_data), 32'h10);
        idle(1); cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // The byte strobe lands on the cycle that would otherwise time out.
        rx(8'h07); rx(8'h09); idle(TO - 1); rx(8'h25);
        chk("tie_noerr", 32'(bus.o_error),    32'd0);
        chk("tie_start", 32'(bus.o_tx_start), 32'd1);
        idle(1); cyc(1'b0, 1'b0, 8'h00, 1'b1);

        // Random traffic: mostly valid opcodes, occasional silence, resets and stray tx_done.
        for (int i = 0; i < 600; i++) begin
            logic [7:0] d;
            if ($urandom_range(0, 3) == 0) d = 8'($urandom);
            else d = {2'($urandom), valid_ops[$urandom_range(0, 7)]};
            if ($urandom_range(0, 50) == 0) idle(TO + 1);
            cyc($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0, d, $urandom_range(0, 5) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
